// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b, LSB first, one full-subtractor cell per clock.
// Optional macro SERIAL_SUB_ADD_EN adds the in_add port, which selects a + b (carry-out on borrow).
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_ADD_EN
    input  logic             in_add,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_br;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic             w_accept;
    logic             w_last;
    logic             w_add;
    logic             w_a0;
    logic             w_b0;
    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_diff_shift;

`ifdef SERIAL_SUB_ADD_EN
    logic r_add;
    assign w_add = r_add;
`else
    assign w_add = 1'b0;
`endif

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign diff      = r_diff;
    assign borrow    = r_borrow;
    assign w_accept  = in_valid && (r_state == S_IDLE);
    assign w_last    = (r_cnt == CW'(WIDTH - 1));

    // One cell serves both modes: the sum bit is identical, only the carry/borrow term differs.
    always_comb begin
        w_a0      = r_a[0];
        w_b0      = r_b[0];
        w_d       = w_a0 ^ w_b0 ^ r_br;
        if (w_add) begin
            w_br_next = (w_a0 & w_b0) | (r_br & (w_a0 ^ w_b0));
        end else begin
            w_br_next = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_br);
        end
        w_diff_shift            = r_diff >> 1;
        w_diff_shift[WIDTH-1]   = w_d;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_next = S_SHIFT;
            S_SHIFT: if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_br     <= 1'b0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
`ifdef SERIAL_SUB_ADD_EN
            r_add    <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_br  <= 1'b0;
            r_cnt <= '0;
`ifdef SERIAL_SUB_ADD_EN
            r_add <= in_add;
`endif
        end else if (r_state == S_SHIFT) begin
            r_a    <= r_a >> 1;
            r_b    <= r_b >> 1;
            r_br   <= w_br_next;
            r_diff <= w_diff_shift;
            // Counter parks on the last index rather than wrapping.
            if (w_last) begin
                r_borrow <= w_br_next;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8 main instance, WIDTH=1 side instance).
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       in_add_s = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] diff;
    logic       borrow;
    logic       busy;

    logic       v1 = 1'b0;
    logic       ir1;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       ov1;
    logic [0:0] d1;
    logic       br1;
    logic       bz1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic prev_ov = 1'b0;

    typedef struct {
        logic [7:0] d;
        logic       br;
        int         acc;
    } exp_t;
    exp_t q[$];

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
`ifdef SERIAL_SUB_ADD_EN
        .in_add(in_add_s),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow(borrow), .busy(busy)
    );

    serial_subtractor #(.WIDTH(1)) dut_w1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1),
        .a(a1), .b(b1),
`ifdef SERIAL_SUB_ADD_EN
        .in_add(1'b0),
`endif
        .out_valid(ov1), .out_ready(1'b1),
        .diff(d1), .borrow(br1), .busy(bz1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: latency on out_valid rise, data on handshake.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (out_valid && !prev_ov) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: out_valid with no op pending, diff=%h", diff);
            end else if (cyc - q[0].acc != 8) begin
                errors++;
                $display("FAIL latency: got %0d cycles, expected 8", cyc - q[0].acc);
            end
        end
        if (out_valid && out_ready && q.size() != 0) begin
            e = q.pop_front();
            chk("diff", 32'(diff), 32'(e.d));
            chk("borrow", 32'(borrow), 32'(e.br));
            $display("result diff=%h borrow=%b (expected %h/%b)", diff, borrow, e.d, e.br);
        end
        prev_ov <= out_valid;
    end

    // Caller is positioned at a negedge.
    task automatic issue(input logic [7:0] ta, input logic [7:0] tb_, input logic tadd,
                         input logic [7:0] ed, input logic eb, input bit push);
        exp_t e;
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        a = ta; b = tb_; in_add_s = tadd; in_valid = 1'b1;
        e.d = ed; e.br = eb; e.acc = cyc + 1;
        if (push) q.push_back(e);
        $display("issue a=%h b=%h add=%b push=%0d", ta, tb_, tadd, push);
        @(negedge clk);
        in_valid = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("in_ready_after_accept", 32'(in_ready), 32'd0);
    endtask

    task automatic drain(input logic [7:0] ed, input logic eb);
        int n = 0;
        while ((q.size() != 0 || !in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", 32'(q.size()), 32'd0);
        @(negedge clk);
        chk("idle_hold_diff", 32'(diff), 32'(ed));
        chk("idle_hold_borrow", 32'(borrow), 32'(eb));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);

        issue(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b1); drain(8'h02, 1'b0);
        issue(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b1); drain(8'hFE, 1'b1);
        issue(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b1); drain(8'hFF, 1'b1);
        issue(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1); drain(8'h00, 1'b0);
        issue(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1); drain(8'h00, 1'b0);
        issue(8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b1); drain(8'h01, 1'b1);

        // Back-pressure in DONE with stray in_valid pulses.
        out_ready = 1'b0;
        issue(8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1);
        begin
            int n = 0;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        chk("bp_reached_done", 32'(out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            a = 8'h11; b = 8'h22; in_valid = 1'b1;
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_diff", 32'(diff), 32'h55);
            chk("bp_borrow", 32'(borrow), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_back_idle", 32'(in_ready), 32'd1);
        chk("bp_out_valid_low", 32'(out_valid), 32'd0);
        chk("bp_queue_empty", 32'(q.size()), 32'd0);

        // Abort mid-SHIFT: result must never appear.
        issue(8'hC3, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_borrow", 32'(borrow), 32'd0);
        issue(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1); drain(8'h7F, 1'b0);

`ifdef SERIAL_SUB_ADD_EN
        issue(8'hF0, 8'h20, 1'b1, 8'h10, 1'b1, 1'b1); drain(8'h10, 1'b1);
        issue(8'hF0, 8'h20, 1'b0, 8'hD0, 1'b0, 1'b1); drain(8'hD0, 1'b0);
`endif

        // WIDTH=1 instance: one SHIFT cycle, then DONE.
        a1 = 1'b0; b1 = 1'b1; v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        chk("w1_shift_out_valid", 32'(ov1), 32'd0);
        chk("w1_shift_busy", 32'(bz1), 32'd1);
        @(negedge clk);
        chk("w1_done_out_valid", 32'(ov1), 32'd1);
        chk("w1_diff", 32'(d1), 32'd1);
        chk("w1_borrow", 32'(br1), 32'd1);
        $display("w1 a=0 b=1 diff=%b borrow=%b", d1, br1);
        @(negedge clk);
        chk("w1_idle", 32'(ir1), 32'd1);

        repeat (3) @(negedge clk);
        chk("final_queue_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
